// File: rtl/clause_bin_ctrl.sv
// Clause-array sequencer: loads/stores a bin between bin memory and the clause
// array, and inserts learnt clauses into the learnt half using a shadow length table.
module clause_bin_ctrl #(
    parameter int NUM_CLAUSES = 8,
    parameter int NUM_VARS    = 8,
    parameter int WIDTH_C_LEN = 4,
    parameter int WIDTH_ADDR  = 10
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_load_i,
    input  logic                                start_store_i,
    input  logic                                add_learntc_i,
    input  logic [WIDTH_ADDR-1:0]               base_addr_i,
    input  logic [NUM_VARS*2-1:0]               learntc_i,
    input  logic [WIDTH_C_LEN-1:0]              learntc_len_i,
    output logic                                mem_rd_o,
    output logic                                mem_wr_o,
    output logic [WIDTH_ADDR-1:0]               mem_addr_o,
    input  logic [NUM_VARS*2+WIDTH_C_LEN-1:0]   mem_rdata_i,
    output logic [NUM_VARS*2+WIDTH_C_LEN-1:0]   mem_wdata_o,
    output logic [NUM_CLAUSES-1:0]              wr_o,
    output logic [NUM_CLAUSES-1:0]              rd_o,
    output logic [NUM_VARS*2-1:0]               clause_o,
    output logic [WIDTH_C_LEN-1:0]              clause_len_o,
    input  logic [NUM_VARS*2-1:0]               clause_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [$clog2(NUM_CLAUSES)-1:0]      insert_slot_o
);

    localparam int CW   = NUM_VARS * 2;
    localparam int DW   = CW + WIDTH_C_LEN;
    localparam int SW   = $clog2(NUM_CLAUSES);
    localparam int KW   = $clog2(NUM_CLAUSES + 1);
    localparam int HALF = NUM_CLAUSES / 2;
    localparam logic [KW-1:0] LAST = KW'(NUM_CLAUSES);

    typedef enum logic [2:0] {IDLE, LOAD, STORE, SELECT, INSERT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [KW-1:0]           cnt_q;
    logic [WIDTH_ADDR-1:0]   base_q;
    logic [CW-1:0]           learntc_q;
    logic [WIDTH_C_LEN-1:0]  learntc_len_q;
    logic [WIDTH_C_LEN-1:0]  shadow_q [NUM_CLAUSES];
    logic [SW-1:0]           insert_slot_q;
    logic [SW-1:0]           sel_slot;
    logic [SW-1:0]           cur_slot;
    logic [SW-1:0]           prev_slot;
    logic                    found_empty;
    logic [WIDTH_C_LEN-1:0]  best_len;

    // The counter runs one past the last slot so the trailing write/memory
    // beat of the one-cycle-latency pipeline happens inside the same state.
    assign cur_slot      = SW'(cnt_q);
    assign prev_slot     = SW'(cnt_q - 1'b1);
    assign insert_slot_o = insert_slot_q;

    // Replacement choice: first empty learnt slot, else longest (lowest index on ties).
    always_comb begin
        sel_slot    = SW'(HALF);
        found_empty = 1'b0;
        best_len    = '0;
        for (int unsigned i = HALF; i < NUM_CLAUSES; i++) begin
            if (!found_empty) begin
                if (shadow_q[SW'(i)] == '0) begin
                    found_empty = 1'b1;
                    sel_slot    = SW'(i);
                end else if (shadow_q[SW'(i)] > best_len) begin
                    best_len = shadow_q[SW'(i)];
                    sel_slot = SW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            base_q        <= '0;
            learntc_q     <= '0;
            learntc_len_q <= '0;
            shadow_q      <= '{default: '0};
            insert_slot_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (start_load_i || start_store_i)
                        base_q <= base_addr_i;
                    if (state_d == SELECT) begin
                        learntc_q     <= learntc_i;
                        learntc_len_q <= learntc_len_i;
                    end
                end
                LOAD: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q != '0)
                        shadow_q[prev_slot] <= mem_rdata_i[DW-1:CW];
                end
                STORE:   cnt_q <= cnt_q + 1'b1;
                SELECT:  insert_slot_q <= sel_slot;
                INSERT:  shadow_q[insert_slot_q] <= learntc_len_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_rd_o     = 1'b0;
        mem_wr_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        wr_o         = '0;
        rd_o         = '0;
        clause_o     = '0;
        clause_len_o = '0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_load_i)       state_d = LOAD;
                else if (start_store_i) state_d = STORE;
                else if (add_learntc_i) state_d = SELECT;
            end
            LOAD: begin
                busy_o = 1'b1;
                if (cnt_q < LAST) begin
                    mem_rd_o   = 1'b1;
                    mem_addr_o = base_q + WIDTH_ADDR'(cnt_q);
                end
                if (cnt_q != '0) begin
                    wr_o[prev_slot] = 1'b1;
                    clause_o        = mem_rdata_i[CW-1:0];
                    clause_len_o    = mem_rdata_i[DW-1:CW];
                end
                if (cnt_q == LAST) state_d = DONE;
            end
            STORE: begin
                busy_o = 1'b1;
                if (cnt_q < LAST)
                    rd_o[cur_slot] = 1'b1;
                if (cnt_q != '0) begin
                    mem_wr_o    = 1'b1;
                    mem_addr_o  = base_q + WIDTH_ADDR'(KW'(cnt_q - 1'b1));
                    mem_wdata_o = {shadow_q[prev_slot], clause_i};
                end
                if (cnt_q == LAST) state_d = DONE;
            end
            SELECT: begin
                busy_o  = 1'b1;
                state_d = INSERT;
            end
            INSERT: begin
                busy_o              = 1'b1;
                wr_o[insert_slot_q] = 1'b1;
                clause_o            = learntc_q;
                clause_len_o        = learntc_len_q;
                state_d             = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_clause_bin_ctrl.sv
// Directed bench for clause_bin_ctrl: load/store/insert timing, slot choice,
// request priority, address wrap and mid-load reset.
module tb_clause_bin_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_load_i, start_store_i, add_learntc_i;
    logic [9:0]  base_addr_i;
    logic [15:0] learntc_i;
    logic [3:0]  learntc_len_i;
    logic        mem_rd_o, mem_wr_o;
    logic [9:0]  mem_addr_o;
    logic [19:0] mem_rdata_i;
    logic [19:0] mem_wdata_o;
    logic [7:0]  wr_o, rd_o;
    logic [15:0] clause_o;
    logic [3:0]  clause_len_o;
    logic [15:0] clause_i;
    logic        busy_o, done_o;
    logic [2:0]  insert_slot_o;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;

    logic [19:0] mem [1024];
    logic [3:0]  exp_len [8];

    clause_bin_ctrl #(
        .NUM_CLAUSES(8),
        .NUM_VARS(8),
        .WIDTH_C_LEN(4),
        .WIDTH_ADDR(10)
    ) dut (
        .clk(clk), .rst(rst),
        .start_load_i(start_load_i), .start_store_i(start_store_i),
        .add_learntc_i(add_learntc_i), .base_addr_i(base_addr_i),
        .learntc_i(learntc_i), .learntc_len_i(learntc_len_i),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i), .mem_wdata_o(mem_wdata_o),
        .wr_o(wr_o), .rd_o(rd_o), .clause_o(clause_o), .clause_len_o(clause_len_o),
        .clause_i(clause_i), .busy_o(busy_o), .done_o(done_o),
        .insert_slot_o(insert_slot_o)
    );

    always #5 clk = ~clk;

    // Bin memory (1-cycle read latency) and clause array returning 0x1234+slot.
    always @(posedge clk) begin
        if (mem_rd_o) mem_rdata_i <= mem[mem_addr_o];
        if (mem_wr_o) wr_cnt <= wr_cnt + 1;
        for (int k = 0; k < 8; k++)
            if (rd_o[k]) clause_i <= 16'(16'h1234 + k);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put_word(input logic [9:0] a, input logic [3:0] len, input logic [15:0] cl);
        mem[a] = {len, cl};
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " mem_rd"}, 32'(mem_rd_o), 0);
        check_eq({tag, " mem_wr"}, 32'(mem_wr_o), 0);
        check_eq({tag, " addr"}, 32'(mem_addr_o), 0);
        check_eq({tag, " wdata"}, 32'(mem_wdata_o), 0);
        check_eq({tag, " wr"}, 32'(wr_o), 0);
        check_eq({tag, " rd"}, 32'(rd_o), 0);
        check_eq({tag, " clause"}, 32'(clause_o), 0);
        check_eq({tag, " len"}, 32'(clause_len_o), 0);
        check_eq({tag, " busy"}, 32'(busy_o), 0);
        check_eq({tag, " done"}, 32'(done_o), 0);
        check_eq({tag, " slot"}, 32'(insert_slot_o), 0);
    endtask

    task automatic run_load(input logic [9:0] base, input bit all_req, input int inj_store);
        logic [9:0] a;
        @(negedge clk);
        start_load_i  = 1'b1;
        base_addr_i   = base;
        start_store_i = all_req;
        add_learntc_i = all_req;
        @(posedge clk); #1;
        start_load_i  = 1'b0;
        start_store_i = 1'b0;
        add_learntc_i = 1'b0;
        base_addr_i   = 10'h155;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check_eq($sformatf("load%03h c%0d mem_rd", base, c), 32'(mem_rd_o), (c <= 8) ? 1 : 0);
            check_eq($sformatf("load%03h c%0d mem_wr", base, c), 32'(mem_wr_o), 0);
            if (c <= 8) begin
                a = 10'(base + 10'(c - 1));
                check_eq($sformatf("load%03h c%0d addr", base, c), 32'(mem_addr_o), 32'(a));
            end
            if (c >= 2 && c <= 9) begin
                a = 10'(base + 10'(c - 2));
                check_eq($sformatf("load%03h c%0d wr", base, c), 32'(wr_o), 32'(1) << (c - 2));
                check_eq($sformatf("load%03h c%0d clause", base, c), 32'(clause_o), 32'(mem[a][15:0]));
                check_eq($sformatf("load%03h c%0d len", base, c), 32'(clause_len_o), 32'(mem[a][19:16]));
                exp_len[c - 2] = mem[a][19:16];
            end else begin
                check_eq($sformatf("load%03h c%0d wr", base, c), 32'(wr_o), 0);
            end
            check_eq($sformatf("load%03h c%0d busy", base, c), 32'(busy_o), (c <= 9) ? 1 : 0);
            check_eq($sformatf("load%03h c%0d done", base, c), 32'(done_o), (c == 10) ? 1 : 0);
            start_store_i = (c == inj_store);
        end
        start_store_i = 1'b0;
    endtask

    task automatic run_store(input logic [9:0] base);
        logic [9:0]  a;
        logic [19:0] d;
        @(negedge clk);
        start_store_i = 1'b1;
        base_addr_i   = base;
        @(posedge clk); #1;
        start_store_i = 1'b0;
        base_addr_i   = 10'h2AA;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check_eq($sformatf("store c%0d rd", c), 32'(rd_o), (c <= 8) ? (32'(1) << (c - 1)) : 0);
            check_eq($sformatf("store c%0d mem_rd", c), 32'(mem_rd_o), 0);
            check_eq($sformatf("store c%0d mem_wr", c), 32'(mem_wr_o), (c >= 2 && c <= 9) ? 1 : 0);
            if (c >= 2 && c <= 9) begin
                a = 10'(base + 10'(c - 2));
                d = {exp_len[c - 2], 16'(16'h1234 + (c - 2))};
                check_eq($sformatf("store c%0d addr", c), 32'(mem_addr_o), 32'(a));
                check_eq($sformatf("store c%0d wdata", c), 32'(mem_wdata_o), 32'(d));
            end
            check_eq($sformatf("store c%0d busy", c), 32'(busy_o), (c <= 9) ? 1 : 0);
            check_eq($sformatf("store c%0d done", c), 32'(done_o), (c == 10) ? 1 : 0);
        end
    endtask

    task automatic run_insert(input logic [15:0] cl, input logic [3:0] len, input int slot);
        @(negedge clk);
        add_learntc_i = 1'b1;
        learntc_i     = cl;
        learntc_len_i = len;
        @(posedge clk); #1;
        add_learntc_i = 1'b0;
        learntc_i     = 16'hFFFF;
        learntc_len_i = 4'hF;
        @(negedge clk);
        check_eq("ins c1 busy", 32'(busy_o), 1);
        check_eq("ins c1 wr", 32'(wr_o), 0);
        check_eq("ins c1 done", 32'(done_o), 0);
        @(negedge clk);
        check_eq("ins c2 wr", 32'(wr_o), 32'(1) << slot);
        check_eq("ins c2 slot", 32'(insert_slot_o), 32'(slot));
        check_eq("ins c2 clause", 32'(clause_o), 32'(cl));
        check_eq("ins c2 len", 32'(clause_len_o), 32'(len));
        check_eq("ins c2 busy", 32'(busy_o), 1);
        @(negedge clk);
        check_eq("ins c3 done", 32'(done_o), 1);
        check_eq("ins c3 busy", 32'(busy_o), 0);
        check_eq("ins c3 wr", 32'(wr_o), 0);
        exp_len[slot] = len;
    endtask

    logic [3:0] lens_b [8] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd3, 4'd0, 4'd5, 4'd0};
    logic [3:0] lens_c [8] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd3, 4'd7, 4'd7, 4'd2};
    int wr_before;

    initial begin
        rst = 1'b1;
        start_load_i = 1'b0; start_store_i = 1'b0; add_learntc_i = 1'b0;
        base_addr_i = '0; learntc_i = '0; learntc_len_i = '0;
        for (int k = 0; k < 8; k++) begin
            put_word(10'(10'h040 + k), 4'(k + 1), 16'(16'hA000 + k));
            put_word(10'(10'h100 + k), lens_b[k], 16'(16'hB000 + k));
            put_word(10'(10'h200 + k), lens_c[k], 16'(16'hC000 + k));
            put_word(10'(10'h3FE + k), 4'(8 - k), 16'(16'hD000 + k));
        end
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Load then store back.
        run_load(10'h040, 1'b0, 0);
        run_store(10'h040);

        // Empty learnt slot wins: {3,0,5,0} -> 5.
        run_load(10'h100, 1'b0, 0);
        run_insert(16'h5A5A, 4'd6, 5);

        // Longest learnt slot, ties to lowest: {3,7,7,2} -> 5, then -> 6.
        run_load(10'h200, 1'b0, 0);
        run_insert(16'h0F0F, 4'd4, 5);
        run_insert(16'h0F0F, 4'd4, 6);
        run_store(10'h300);

        // Simultaneous requests: only the load runs; mid-load store is ignored.
        wr_before = wr_cnt;
        run_load(10'h040, 1'b1, 4);
        repeat (12) @(negedge clk);
        check_eq("prio no mem writes", 32'(wr_cnt), 32'(wr_before));
        check_eq("prio idle busy", 32'(busy_o), 0);
        check_eq("prio slot kept", 32'(insert_slot_o), 6);

        // Address wrap.
        run_load(10'h3FE, 1'b0, 0);

        // Reset in load cycle 5.
        @(negedge clk);
        start_load_i = 1'b1;
        base_addr_i  = 10'h040;
        @(posedge clk); #1;
        start_load_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 5) rst = 1'b1;
        end
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) exp_len[k] = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("midrst post c%0d done", c), 32'(done_o), 0);
        end
        run_insert(16'hBEEF, 4'd9, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clause_bin_ctrl.md
# clause_bin_ctrl

Sequencer that owns the write/read ports of the clause array. It loads a bin of `NUM_CLAUSES` clauses from bin memory into the array, stores the array contents back to bin memory, and inserts learnt clauses into the learnt half of the array. It sits between the bin manager (memory side) and the clause array. It keeps a shadow copy of every slot's clause length so it can choose the replacement slot.

## Interface
- `NUM_CLAUSES`, 8: array slots; must be even. Slots `0..N/2-1` hold original clauses, slots `N/2..N-1` hold learnt clauses.
- `NUM_VARS`, 8: variables per clause, 2 bits each.
- `WIDTH_C_LEN`, 4: clause length width.
- `WIDTH_ADDR`, 10: bin memory address width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_load_i`  in  1  load request; sampled in IDLE only.
- `start_store_i`  in  1  store request; sampled in IDLE only.
- `add_learntc_i`  in  1  learnt-clause insert request; sampled in IDLE only.
- `base_addr_i`  in  WIDTH_ADDR  bin base address; latched on accept.
- `learntc_i`  in  NUM_VARS*2  learnt clause; latched on accept.
- `learntc_len_i`  in  WIDTH_C_LEN  learnt clause length; latched on accept.
- `mem_rd_o`  out  1  memory read strobe; data returns 1 cycle later.
- `mem_wr_o`  out  1  memory write strobe.
- `mem_addr_o`  out  WIDTH_ADDR  memory address.
- `mem_rdata_i`  in  NUM_VARS*2+WIDTH_C_LEN  packed as {len, clause}.
- `mem_wdata_o`  out  NUM_VARS*2+WIDTH_C_LEN  packed as {len, clause}.
- `wr_o`  out  NUM_CLAUSES  one-hot array write enable.
- `rd_o`  out  NUM_CLAUSES  one-hot array read enable; array data is valid the next cycle.
- `clause_o`  out  NUM_VARS*2  clause to the array.
- `clause_len_o`  out  WIDTH_C_LEN  length to the array.
- `clause_i`  in  NUM_VARS*2  clause read back from the array.
- `busy_o`  out  1  operation in progress.
- `done_o`  out  1  single-cycle completion pulse.
- `insert_slot_o`  out  log2(NUM_CLAUSES)  slot used by the last insert.

## Operation
- States: IDLE, LOAD, STORE, SELECT, INSERT, DONE.
- IDLE accept priority: load > store > insert. Lower-priority requests raised in the same cycle are dropped. Requests raised outside IDLE are ignored; they are not queued.
- LOAD, with counter k = 0..N-1:
  - Issue `mem_rd_o` at `base+k`.
  - One cycle later, assert `wr_o[k]` with `clause_o`/`clause_len_o` driven combinationally from `mem_rdata_i`.
  - Write the length into shadow[k].
  - Exit after the last write.
- STORE, with counter k = 0..N-1:
  - Assert `rd_o[k]`.
  - One cycle later, assert `mem_wr_o` at `base+k` with data {shadow[k], `clause_i`}.
- SELECT: evaluate learnt slots `N/2..N-1` in one cycle and register the chosen slot s:
  - Lowest-index slot with shadow length 0 (empty).
  - Otherwise, the slot with the maximum shadow length; ties go to the lowest index.
- INSERT: assert `wr_o[s]` with the latched learnt clause and length, set shadow[s] to the learnt length, and update `insert_slot_o` to s.
- DONE: `done_o` high for one cycle, then return to IDLE.
- Address arithmetic is `base+k` modulo 2^WIDTH_ADDR; wrap-around is permitted.
- Loading a clause of length 0 marks that slot empty.
- Reset (also mid-operation):
  - State goes to IDLE and shadow lengths clear to 0.
  - `insert_slot_o`=0.
  - All strobes, `wr_o`, `rd_o`, `busy_o` and `done_o` are 0.
  - `mem_addr_o`, `mem_wdata_o`, `clause_o` and `clause_len_o` are 0.
  - A partially loaded bin is abandoned; no completion pulse is issued.

## Timing
- Cycle 0 is the clock edge that accepts a request.
- Load:
  - `mem_rd_o` is high in cycles 1..N with `mem_addr_o`=base+(c-1).
  - `wr_o` = one-hot (c-2) in cycles 2..N+1.
  - `busy_o` is high in cycles 1..N+1.
  - `done_o` is high in cycle N+2, with `busy_o` low.
- Store:
  - `rd_o` = one-hot (c-1) in cycles 1..N.
  - `mem_wr_o` is high in cycles 2..N+1 with address base+(c-2).
  - `done_o` is high in cycle N+2.
- Insert:
  - Cycle 1 is SELECT, with `busy_o` high.
  - Cycle 2 has `wr_o[s]` asserted and `insert_slot_o` valid; `insert_slot_o` is held until the next insert.
  - `done_o` is high in cycle 3.
- At most one bit of `wr_o`/`rd_o` is set in any cycle.
- `mem_rd_o` and `mem_wr_o` are never set together.
- A new request may be accepted in the cycle after `done_o`.

## Test plan
All scenarios use N=8, NUM_VARS=8, WIDTH_C_LEN=4.
- Load at base 0x040, with memory holding len = k+1 at address 0x040+k:
  - `wr_o` steps 0x01..0x80 over cycles 2..9, each slot receiving the matching data.
  - `done_o` pulses in cycle 10.
- Store after that load, with the array returning clause 0x1234+k:
  - `mem_wr_o` is high in cycles 2..9 at addresses 0x040..0x047.
  - `mem_wdata_o` = {k+1, 0x1234+k}.
- Insert with shadow lengths slots 4..7 = {3,0,5,0}: `insert_slot_o`=5 and `wr_o`=0x20 in cycle 2.
- Insert with shadow lengths slots 4..7 = {3,7,7,2} and learnt len 4: `wr_o`=0x20 and shadow[5]=4. A following insert with the same clause selects slot 6.
- Simultaneous `start_load_i`, `start_store_i` and `add_learntc_i` in IDLE:
  - Only the load runs.
  - A `start_store_i` pulse during the load is ignored: no memory writes follow its `done_o`.
- Load with base 0x3FE: addresses wrap 0x3FE, 0x3FF, 0x000..0x005.
- `rst` in load cycle 5: next cycle all outputs are 0 and state is IDLE; a subsequent insert selects slot 4 (all slots empty).
